// File: rtl/cas_pkg.sv
// Shared definitions for the cassette playback source: FSM states, FSK half-cycle defaults.
package cas_pkg;

   localparam int CAS_CLK_HZ = 57272000;
   localparam int HALF_0_DEF = 23863;
   localparam int HALF_1_DEF = 11932;
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_STALL,
      ST_EOT
   } cas_state_t;

   // Terminal count of the half-cycle counter for a bit value b.
   function automatic logic [CNT_W-1:0] half_last(input logic b, input int h0, input int h1);
      return b ? CNT_W'(h1 - 1) : CNT_W'(h0 - 1);
   endfunction

endpackage

// File: rtl/cas_fetch.sv
// Byte fetcher: one outstanding read, one-byte prefetch buffer, byte_pos counter.
// Response latency is free; a read issued before a rewind is marked stale and its data dropped.
module cas_fetch
   import cas_pkg::*;
#(
   parameter int AW = 16
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          rewind,
   input  logic [AW-1:0] tape_len,
   input  logic          take,
   input  logic          rd_valid,
   input  logic [7:0]    rd_data,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] byte_pos,
   output logic          buf_vld,
   output logic [7:0]    buf_dat
);

   logic pend;
   logic stale;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_req   <= 1'b0;
         rd_addr  <= '0;
         byte_pos <= '0;
         buf_vld  <= 1'b0;
         buf_dat  <= '0;
         pend     <= 1'b0;
         stale    <= 1'b0;
      end else begin
         rd_req <= 1'b0;
         if (rewind) begin
            byte_pos <= '0;
            rd_addr  <= '0;
            buf_vld  <= 1'b0;
            // No new read until the in-flight one has returned and been discarded.
            pend     <= pend && !rd_valid;
            stale    <= pend && !rd_valid;
         end else begin
            if (pend && rd_valid) begin
               pend  <= 1'b0;
               stale <= 1'b0;
               if (!stale) begin
                  buf_vld  <= 1'b1;
                  buf_dat  <= rd_data;
                  byte_pos <= byte_pos + 1'b1;
               end
            end else if (!pend && !buf_vld && run && (byte_pos < tape_len)) begin
               rd_req  <= 1'b1;
               rd_addr <= byte_pos;
               pend    <= 1'b1;
            end
            if (take) begin
               buf_vld <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/cas_player.sv
// Cassette playback: FSK-encodes buffered .CAS bytes LSB first onto casdout, gated by the motor relay.
// Each bit is one full square cycle; a missing byte at a bit boundary stalls with casdout low.
module cas_player
   import cas_pkg::*;
#(
   parameter int HALF_0 = HALF_0_DEF,
   parameter int HALF_1 = HALF_1_DEF,
   parameter int AW     = 16
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          motor,
   input  logic          tape_loaded,
   input  logic [AW-1:0] tape_len,
   input  logic          rewind,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_valid,
   input  logic [7:0]    rd_data,
   output logic          casdout,
   output logic          playing,
   output logic          eot,
   output logic          underrun,
   output logic [AW-1:0] byte_pos
);

   cas_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       sr;
   logic             sr_vld;
   logic [2:0]       bit_idx;
   logic             cur_b;
   logic             buf_vld;
   logic [7:0]       buf_dat;
   logic             take;
   logic             run;
   logic             half_done;
   logic             last_bit;
   logic             done_all;

   assign run       = motor & tape_loaded;
   assign half_done = (cnt == half_last(cur_b, HALF_0, HALF_1));
   assign last_bit  = (bit_idx == 3'd7);
   assign done_all  = (byte_pos >= tape_len);

   // Buffer -> shift register transfers; must match the loads in the FSM below.
   always_comb begin
      take = 1'b0;
      if (!rewind) begin
         case (state)
            ST_IDLE:  take = run && !sr_vld && buf_vld;
            ST_STALL: take = run && buf_vld;
            ST_LOW:   take = half_done && last_bit && buf_vld;
            default:  take = 1'b0;
         endcase
      end
   end

   cas_fetch #(.AW(AW)) u_fetch (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .rewind   (rewind),
      .tape_len (tape_len),
      .take     (take),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .byte_pos (byte_pos),
      .buf_vld  (buf_vld),
      .buf_dat  (buf_dat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sr       <= '0;
         sr_vld   <= 1'b0;
         bit_idx  <= '0;
         cur_b    <= 1'b0;
         casdout  <= 1'b0;
         playing  <= 1'b0;
         eot      <= 1'b0;
         underrun <= 1'b0;
      end else if (rewind) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sr_vld   <= 1'b0;
         bit_idx  <= '0;
         casdout  <= 1'b0;
         playing  <= 1'b0;
         eot      <= 1'b0;
         underrun <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run && sr_vld) begin
                  cur_b   <= sr[0];
                  cnt     <= '0;
                  casdout <= 1'b1;
                  playing <= 1'b1;
                  state   <= ST_HIGH;
               end else if (run && buf_vld) begin
                  sr      <= buf_dat;
                  sr_vld  <= 1'b1;
                  bit_idx <= '0;
                  cur_b   <= buf_dat[0];
                  cnt     <= '0;
                  casdout <= 1'b1;
                  playing <= 1'b1;
                  state   <= ST_HIGH;
               end else if (run && done_all) begin
                  eot   <= 1'b1;
                  state <= ST_EOT;
               end
            end
            ST_HIGH: begin
               if (half_done) begin
                  cnt     <= '0;
                  casdout <= 1'b0;
                  state   <= ST_LOW;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_LOW: begin
               if (!half_done) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
                  if (last_bit) begin
                     bit_idx <= '0;
                     sr_vld  <= buf_vld;
                     if (buf_vld) begin
                        sr <= buf_dat;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     sr      <= {1'b0, sr[7:1]};
                  end
                  // Motor is only honoured here, so a running bit always completes.
                  if (!run) begin
                     playing <= 1'b0;
                     state   <= ST_IDLE;
                  end else if (!last_bit) begin
                     cur_b   <= sr[1];
                     casdout <= 1'b1;
                     state   <= ST_HIGH;
                  end else if (buf_vld) begin
                     cur_b   <= buf_dat[0];
                     casdout <= 1'b1;
                     state   <= ST_HIGH;
                  end else if (done_all) begin
                     eot     <= 1'b1;
                     playing <= 1'b0;
                     state   <= ST_EOT;
                  end else begin
                     underrun <= 1'b1;
                     playing  <= 1'b0;
                     state    <= ST_STALL;
                  end
               end
            end
            ST_STALL: begin
               if (!run) begin
                  state <= ST_IDLE;
               end else if (buf_vld) begin
                  sr      <= buf_dat;
                  sr_vld  <= 1'b1;
                  bit_idx <= '0;
                  cur_b   <= buf_dat[0];
                  cnt     <= '0;
                  casdout <= 1'b1;
                  playing <= 1'b1;
                  state   <= ST_HIGH;
               end
            end
            ST_EOT: begin
               casdout <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cas_player.sv
// Randomized and directed playback bench; a tape/memory model and a waveform decoder check casdout.
module tb_cas_player;

   localparam int H0 = 8;
   localparam int H1 = 4;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          motor;
   logic          tape_loaded;
   logic          rewind;
   logic          rd_valid;
   logic [AW-1:0] tape_len;
   logic [7:0]    rd_data;
   logic          rd_req;
   logic          casdout;
   logic          playing;
   logic          eot;
   logic          underrun;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] byte_pos;

   always #5 clk = ~clk;

   cas_player #(.HALF_0(H0), .HALF_1(H1), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .motor       (motor),
      .tape_loaded (tape_loaded),
      .tape_len    (tape_len),
      .rewind      (rewind),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .casdout     (casdout),
      .playing     (playing),
      .eot         (eot),
      .underrun    (underrun),
      .byte_pos    (byte_pos)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input longint got, input longint want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   // Tape memory model plus casdout pulse recorder, both sampled on the falling edge.
   logic [7:0]    mem [16];
   int            lat = 1;
   int            cd = 0;
   logic [AW-1:0] req_addr = '0;
   logic [AW-1:0] req_log [$];
   int            hi_len [$];
   int            lo_len [$];
   int            run_len = 0;
   logic          prev = 1'b0;
   int            rises = 0;
   int            clk_cnt = 0;
   int            first_rise_t = 0;
   int            eot_t = 0;
   bit            eot_seen = 1'b0;

   always @(negedge clk) begin
      clk_cnt++;
      rd_valid = 1'b0;
      if (!reset) begin
         cd = 0;
         req_log.delete();
         hi_len.delete();
         lo_len.delete();
         run_len = 0;
         prev = 1'b0;
         rises = 0;
         eot_seen = 1'b0;
      end else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               rd_valid = 1'b1;
               rd_data  = mem[req_addr[3:0]];
            end
         end
         if (rd_req) begin
            req_log.push_back(rd_addr);
            req_addr = rd_addr;
            cd = lat;
         end
         if (casdout !== prev) begin
            if (prev) hi_len.push_back(run_len);
            else if (rises > 0) lo_len.push_back(run_len);
            if (casdout) begin
               if (rises == 0) first_rise_t = clk_cnt;
               rises++;
            end
            run_len = 1;
            prev = casdout;
         end else begin
            run_len++;
         end
         if (eot && !eot_seen) begin
            eot_seen = 1'b1;
            eot_t = clk_cnt;
            if (hi_len.size() > lo_len.size()) lo_len.push_back(run_len - 1);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int len, input bit chk);
      tick(1);
      reset = 1'b0;
      motor = 1'b0;
      tape_loaded = 1'b1;
      rewind = 1'b0;
      tape_len = AW'(len);
      tick(3);
      if (chk) begin
         check("rst.casdout", casdout, 0);
         check("rst.rd_req", rd_req, 0);
         check("rst.rd_addr", rd_addr, 0);
         check("rst.playing", playing, 0);
         check("rst.eot", eot, 0);
         check("rst.underrun", underrun, 0);
         check("rst.byte_pos", byte_pos, 0);
      end
      reset = 1'b1;
      tick(1);
   endtask

   task automatic wait_eot(input string tag, input int budget);
      int i = 0;
      while (!eot_seen && i < budget) begin
         tick(1);
         i++;
      end
      check({tag, ".eot_reached"}, eot_seen, 1);
      tick(2);
   endtask

   // Reference: bit k of the tape is mem[k/8][k%8]; each bit is a high and a low of HALF(bit).
   function automatic int half_of(input int k);
      return mem[k / 8][k % 8] ? H1 : H0;
   endfunction

   task automatic check_wave(input string tag, input int n, output int gaps, output int gap_at);
      gaps = 0;
      gap_at = -1;
      check({tag, ".pulses"}, hi_len.size(), 8 * n);
      for (int k = 0; k < hi_len.size() && k < 8 * n; k++)
         check($sformatf("%s.hi%0d", tag, k), hi_len[k], half_of(k));
      for (int k = 0; k < lo_len.size() && k < 8 * n; k++) begin
         if (lo_len[k] != half_of(k)) begin
            gaps++;
            if (gap_at < 0) gap_at = k;
         end
      end
   endtask

   task automatic play_case(input string tag, input int n, input int l, input bit exp_under);
      int dur = 0;
      int gaps;
      int gap_at;
      lat = l;
      do_reset(n, 1'b0);
      motor = 1'b1;
      wait_eot(tag, 6000);
      check_wave(tag, n, gaps, gap_at);
      for (int k = 0; k < 8 * n; k++) dur += 2 * half_of(k);
      check({tag, ".underrun"}, underrun, exp_under);
      check({tag, ".byte_pos"}, byte_pos, n);
      check({tag, ".casdout"}, casdout, 0);
      check({tag, ".nreq"}, req_log.size(), n);
      for (int k = 0; k < req_log.size() && k < n; k++)
         check($sformatf("%s.addr%0d", tag, k), req_log[k], k);
      if (exp_under) begin
         check({tag, ".gaps"}, gaps, 1);
         check({tag, ".gap_at"}, gap_at, 7);
      end else begin
         check({tag, ".gaps"}, gaps, 0);
         check({tag, ".duration"}, eot_t - first_rise_t, dur);
      end
      motor = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      int gaps;
      int gap_at;
      int n;
      reset = 1'b0;
      motor = 1'b0;
      tape_loaded = 1'b0;
      rewind = 1'b0;
      tape_len = '0;
      rd_valid = 1'b0;
      rd_data = '0;

      do_reset(1, 1'b1);

      mem[0] = 8'h55;
      play_case("b55", 1, 1, 1'b0);

      mem[0] = 8'h3C;
      mem[1] = 8'hFF;
      play_case("b3cff", 2, 1, 1'b0);

      mem[0] = 8'h00;
      mem[1] = 8'h00;
      play_case("under", 2, 150, 1'b1);

      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 4));
         for (int b = 0; b < n; b++) mem[b] = 8'($urandom);
         play_case($sformatf("rnd%0d", r), n, int'($urandom_range(1, 6)), 1'b0);
      end

      // Motor drop during the high half of bit 3.
      mem[0] = 8'($urandom);
      lat = 1;
      do_reset(1, 1'b0);
      motor = 1'b1;
      i = 0;
      while (rises < 4 && i < 500) begin
         tick(1);
         i++;
      end
      check("md.rises", rises, 4);
      motor = 1'b0;
      i = 0;
      while (playing && i < 100) begin
         tick(1);
         i++;
      end
      tick(20);
      check("md.idle_casdout", casdout, 0);
      check("md.idle_playing", playing, 0);
      check("md.idle_pulses", hi_len.size(), 4);
      check("md.idle_eot", eot, 0);
      motor = 1'b1;
      wait_eot("md", 2000);
      check_wave("md", 1, gaps, gap_at);
      check("md.gaps", gaps, 1);
      check("md.gap_at", gap_at, 3);
      check("md.byte_pos", byte_pos, 1);
      check("md.underrun", underrun, 0);
      motor = 1'b0;

      // Rewind one clock after the first read; its response must be discarded.
      for (int b = 0; b < 3; b++) mem[b] = 8'($urandom);
      lat = 3;
      do_reset(3, 1'b0);
      motor = 1'b1;
      i = 0;
      while (req_log.size() == 0 && i < 20) begin
         tick(1);
         i++;
      end
      check("rw.first_req", req_log.size(), 1);
      tick(1);
      rewind = 1'b1;
      tick(1);
      rewind = 1'b0;
      tick(3);
      check("rw.byte_pos_after_stale", byte_pos, 0);
      wait_eot("rw", 3000);
      check_wave("rw", 3, gaps, gap_at);
      check("rw.gaps", gaps, 0);
      check("rw.nreq", req_log.size(), 4);
      for (int k = 1; k < req_log.size() && k < 4; k++)
         check($sformatf("rw.addr%0d", k), req_log[k], k - 1);
      check("rw.byte_pos", byte_pos, 3);
      rewind = 1'b1;
      tick(1);
      check("rw.clr_eot", eot, 0);
      check("rw.clr_byte_pos", byte_pos, 0);
      check("rw.clr_casdout", casdout, 0);
      check("rw.clr_playing", playing, 0);
      rewind = 1'b0;
      motor = 1'b0;

      // Empty tape: immediate end of tape, never a read, never a pulse.
      do_reset(0, 1'b0);
      motor = 1'b1;
      tick(1);
      check("z.eot", eot, 1);
      tick(20);
      check("z.nreq", req_log.size(), 0);
      check("z.rises", rises, 0);
      check("z.casdout", casdout, 0);
      check("z.playing", playing, 0);
      motor = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
